// File: rtl/prefix_adder_arbiter.sv
// prefix_adder_arbiter
//   Shares one 6-bit prefix adder among NUM_REQ requesters. Round-robin grant,
//   one operation in flight, valid/ready on both request and response sides.
//   The adder sees only registered operands, so its path starts at flops.
// Ports
//   clk, rst_n           clock, synchronous active-low reset
//   req_valid/req_ready  per-requester handshake; req_ready is one-hot in IDLE
//   req_x/req_y/req_cin  per-requester operands (requester i in req_x[i])
//   resp_valid/ready     result handshake
//   resp_s, resp_id      (X+Y+cin) mod 64 and the owning requester index
//   op_count             completed response handshakes, wraps

// 6-bit Kogge-Stone adder; carry-in is folded into bit 0's generate term.
module prefix_adder (
    input  logic [5:0] x,
    input  logic [5:0] y,
    input  logic       c_in,
    output logic [5:0] s
);
    logic [5:0] hs;
    logic [5:0] gl [4];
    logic [5:0] pl [4];

    always_comb begin
        hs    = x ^ y;
        gl[0] = x & y;
        pl[0] = hs;
        gl[0][0] = (x[0] & y[0]) | (hs[0] & c_in);
        for (int l = 0; l < 3; l++) begin
            for (int i = 0; i < 6; i++) begin
                if (i >= (1 << l)) begin
                    gl[l+1][i] = gl[l][i] | (pl[l][i] & gl[l][i - (1 << l)]);
                    pl[l+1][i] = pl[l][i] & pl[l][i - (1 << l)];
                end else begin
                    gl[l+1][i] = gl[l][i];
                    pl[l+1][i] = pl[l][i];
                end
            end
        end
        // carry into bit i is the group generate of bits [i-1:0]
        s = hs ^ {gl[3][4:0], c_in};
    end
endmodule

module prefix_adder_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int CNT_W   = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0][5:0]       req_x,
    input  logic [NUM_REQ-1:0][5:0]       req_y,
    input  logic [NUM_REQ-1:0]            req_cin,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [5:0]                    resp_s,
    output logic [ID_W-1:0]               resp_id,
    output logic [CNT_W-1:0]              op_count
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    typedef struct packed {
        logic [5:0]      x;
        logic [5:0]      y;
        logic            cin;
        logic [ID_W-1:0] id;
    } op_t;

    state_t          state;
    op_t             op;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] gnt_idx;
    logic            gnt_any;
    logic [5:0]      sum;

    // (base + off) mod NUM_REQ for off < NUM_REQ; works for non power-of-2 counts
    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int off);
        int j;
        j = int'(base) + off;
        if (j >= NUM_REQ) j = j - NUM_REQ;
        return ID_W'(j);
    endfunction

    // Scan from rr_ptr upward; descending loop so the nearest valid wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[wrap_idx(rr_ptr, k)]) begin
                gnt_any = 1'b1;
                gnt_idx = wrap_idx(rr_ptr, k);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && gnt_any) req_ready[gnt_idx] = 1'b1;
    end

    prefix_adder u_add (
        .x    (op.x),
        .y    (op.y),
        .c_in (op.cin),
        .s    (sum)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            op         <= '0;
            rr_ptr     <= '0;
            resp_valid <= 1'b0;
            resp_s     <= '0;
            resp_id    <= '0;
            op_count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // a grant is always a handshake: ready only lands on a valid line
                    if (gnt_any) begin
                        op.x   <= req_x[gnt_idx];
                        op.y   <= req_y[gnt_idx];
                        op.cin <= req_cin[gnt_idx];
                        op.id  <= gnt_idx;
                        rr_ptr <= wrap_idx(gnt_idx, 1);
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    resp_s     <= sum;
                    resp_id    <= op.id;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        op_count   <= op_count + CNT_W'(1);
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
